// File: rtl/fb_pkg.sv
// fb_pkg: shared types, frame-buffer geometry and address helper for the
// frame-buffer arbiter.
//   state_t    - arbiter FSM states
//   FB_SIZE    - number of addressable pixels (H_RES*V_RES)
//   xy_to_addr - linear address of pixel (x, y) for the default 640-pixel stride
package fb_pkg;

  localparam int unsigned FB_H_RES  = 640;
  localparam int unsigned FB_V_RES  = 480;
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_SIZE   = FB_H_RES * FB_V_RES;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DISP  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // y*640 + x as two shifts and adds, evaluated at full address width
  function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [9:0] x,
                                                      input logic [9:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = FB_ADDR_W'(y);
    return (yw << 9) + (yw << 7) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_delay_line.sv
// fb_delay_line: DEPTH-stage shift register with synchronous reset to RST_VAL.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; flushes every stage to RST_VAL
//   din  - WIDTH-bit input
//   dout - din delayed by DEPTH cycles
module fb_delay_line #(
  parameter int unsigned       DEPTH   = 1,
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain; stage 0 captures the input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one single-port frame-buffer RAM between the VGA
// display fetch (owns the RAM in the active region) and a one-entry draw
// write buffer that drains only during blanking.
// Ports:
//   i_clk, i_rst                 - pixel clock, synchronous active-high reset
//   i_x, i_y, i_blank_n, i_hs, i_vs - timing generator inputs
//   o_pixel, o_blank_n, o_hs, o_vs  - DAC-side outputs, delayed by RD_LAT
//   i_wr_valid/o_wr_ready/i_wr_addr/i_wr_data - draw-engine write handshake
//   o_wr_done, o_wr_err          - write committed / write dropped (out of range)
//   o_mem_addr, o_mem_wdata, o_mem_we, i_mem_rdata - RAM interface
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned H_RES  = FB_H_RES,
  parameter int unsigned V_RES  = FB_V_RES,
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_blank_n,
  input  logic              i_hs,
  input  logic              i_vs,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_blank_n,
  output logic              o_hs,
  output logic              o_vs,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_done,
  output logic              o_wr_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(H_RES * V_RES);

  state_t              state_q, state_d;
  logic                full_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                wr_err_q;
  logic [ADDR_W-1:0]   disp_addr;
  logic                accept;
  logic                in_range;
  logic [2:0]          sync_dly;

  // Display fetch address: shift-add for the default stride, multiply otherwise
  if (H_RES == FB_H_RES && ADDR_W == FB_ADDR_W) begin : g_addr_shift
    assign disp_addr = xy_to_addr(i_x, i_y);
  end else begin : g_addr_mul
    assign disp_addr = ADDR_W'(i_y) * ADDR_W'(H_RES) + ADDR_W'(i_x);
  end

  // Write handshake; out-of-range writes are accepted but never stored
  assign o_wr_ready = ~i_rst & ~full_q;
  assign accept     = i_wr_valid & o_wr_ready;
  assign in_range   = {1'b0, i_wr_addr} < FB_LIMIT;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM-side outputs; the decision acts in the cycle it is made
  // so the first blank cycle can already carry the write
  always_comb begin
    state_d    = S_IDLE;
    o_mem_we   = 1'b0;
    o_wr_done  = 1'b0;
    o_mem_addr = last_addr_q;
    if (i_rst) begin
      state_d = S_IDLE;
    end else if (i_blank_n) begin
      state_d = S_DISP;
    end else if (full_q && state_q != S_WRITE) begin
      state_d = S_WRITE;
    end
    case (state_d)
      S_DISP: begin
        o_mem_addr = disp_addr;
      end
      S_WRITE: begin
        o_mem_addr = hold_addr_q;
        o_mem_we   = 1'b1;
        o_wr_done  = 1'b1;
      end
      default: begin
        if (i_rst) begin
          o_mem_addr = '0;
        end
      end
    endcase
  end

  assign o_mem_wdata = hold_data_q;

  // Holding register, last-address hold and error pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      last_addr_q <= o_mem_addr;
      wr_err_q    <= accept & ~in_range;
      if (state_d == S_WRITE) begin
        full_q <= 1'b0;
      end else if (accept && in_range) begin
        full_q      <= 1'b1;
        hold_addr_q <= i_wr_addr;
        hold_data_q <= i_wr_data;
      end
    end
  end

  assign o_wr_err = wr_err_q;

  // blank_n/hs/vs follow the RAM read latency
  fb_delay_line #(
    .DEPTH   (RD_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b011)
  ) u_sync_dly (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  ({i_blank_n, i_hs, i_vs}),
    .dout (sync_dly)
  );

  assign {o_blank_n, o_hs, o_vs} = sync_dly;

  // Read data is only meaningful while the delayed blank says active
  assign o_pixel = o_blank_n ? i_mem_rdata : '0;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed and randomised checks of fb_mem_arbiter with a
// RAM model returning addr[7:0] after one cycle.
module tb_fb_mem_arbiter;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_LAT  = 1;
  localparam int          FB_SIZE = 307200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [9:0]        x = '0;
  logic [9:0]        y = '0;
  logic              blank_n = 1'b0;
  logic              hs = 1'b1;
  logic              vs = 1'b1;
  logic [DATA_W-1:0] pixel;
  logic              o_blank;
  logic              o_hsync;
  logic              o_vsync;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_done;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  fb_mem_arbiter #(
    .H_RES (640), .V_RES (480), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (RD_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_x         (x),
    .i_y         (y),
    .i_blank_n   (blank_n),
    .i_hs        (hs),
    .i_vs        (vs),
    .o_pixel     (pixel),
    .o_blank_n   (o_blank),
    .o_hs        (o_hsync),
    .o_vs        (o_vsync),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_done   (wr_done),
    .o_wr_err    (wr_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata)
  );

  // RAM model: read data is the low byte of the address, one cycle later
  always_ff @(posedge clk) mem_rdata <= mem_addr[7:0];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  wq[$];
  logic [10:0] pq[$];
  logic m_full = 1'b0;
  logic m_err  = 1'b0;
  int   we_seen = 0;
  int   n_acc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; x = '0; y = '0; blank_n = 1'b0; hs = 1'b1; vs = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      check("rst_we",    32'(mem_we),   32'd0);
      check("rst_addr",  32'(mem_addr), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd0);
      check("rst_done",  32'(wr_done),  32'd0);
      if (i > 0) begin
        check("rst_pixel", 32'(pixel),   32'd0);
        check("rst_blank", 32'(o_blank), 32'd0);
        check("rst_hs",    32'(o_hsync), 32'd1);
        check("rst_vs",    32'(o_vsync), 32'd1);
        check("rst_err",   32'(wr_err),  32'd0);
      end
    end
    m_full = 1'b0;
    m_err  = 1'b0;
    wq.delete();
    pq.delete();
    for (int i = 0; i < int'(RD_LAT); i++) pq.push_back({1'b0, 1'b1, 1'b1, 8'h00});
  endtask

  // One pixel clock: drive timing and write request, check, advance the model
  task automatic cycle(input int xx, input int yy, input logic v,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic bl, h, vv, acc, exp_we;
    logic [7:0]  ep;
    logic [10:0] exp_bus;
    wr_t w;
    bl = (xx < 640) && (yy < 480);
    h  = !(xx >= 656 && xx < 752);
    vv = !(yy == 490 || yy == 491);
    @(posedge clk); #1;
    rst = 1'b0; x = 10'(xx); y = 10'(yy); blank_n = bl; hs = h; vs = vv;
    wr_valid = v; wr_addr = a; wr_data = d;
    @(negedge clk);
    exp_we = !bl && m_full;
    check("ready", 32'(wr_ready), 32'(!m_full));
    check("we",    32'(mem_we),   32'(exp_we));
    check("done",  32'(wr_done),  32'(exp_we));
    check("err",   32'(wr_err),   32'(m_err));
    if (bl) check("disp_addr", 32'(mem_addr), 32'(yy * 640 + xx));
    if (mem_we === 1'b1) begin
      we_seen++;
      check("wq_has_entry", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("wr_addr", 32'(mem_addr),  32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end
    ep = bl ? 8'(yy * 640 + xx) : 8'h00;
    pq.push_back({bl, h, vv, ep});
    if (pq.size() > int'(RD_LAT)) begin
      exp_bus = pq.pop_front();
      check("pix_bus", 32'({o_blank, o_hsync, o_vsync, pixel}), 32'(exp_bus));
    end
    acc   = v && !m_full;
    m_err = acc && (32'(a) >= FB_SIZE);
    if (exp_we) begin
      m_full = 1'b0;
    end else if (acc && (32'(a) < FB_SIZE)) begin
      m_full = 1'b1;
      n_acc++;
      wq.push_back({a, d});
    end
  endtask

  initial begin
    int base;
    // reset held 3 cycles
    reset_cycles(3);
    cycle(0, 2, 1'b0, '0, '0);
    check("ready_after_rst", 32'(wr_ready), 32'd1);

    // display address and pixel alignment
    for (int i = 1; i < 5; i++) cycle(i, 2, 1'b0, '0, '0);
    cycle(5, 2, 1'b0, '0, '0);
    check("addr_5_2", 32'(mem_addr), 32'd1285);
    cycle(6, 2, 1'b0, '0, '0);
    check("pixel_5_2", 32'(pixel), 32'h05);
    check("blank_5_2", 32'(o_blank), 32'd1);

    // buffered write drains on the first blank cycle
    for (int i = 7; i < 20; i++) cycle(i, 2, 1'b0, '0, '0);
    cycle(20, 2, 1'b1, 19'd1000, 8'hAB);
    cycle(21, 2, 1'b0, '0, '0);
    check("ready_held", 32'(wr_ready), 32'd0);
    base = we_seen;
    for (int i = 22; i < 640; i++) cycle(i, 2, 1'b0, '0, '0);
    check("no_we_active", 32'(we_seen - base), 32'd0);
    cycle(640, 2, 1'b0, '0, '0);
    check("drain_we",    32'(mem_we),    32'd1);
    check("drain_addr",  32'(mem_addr),  32'd1000);
    check("drain_data",  32'(mem_wdata), 32'hAB);
    check("drain_done",  32'(wr_done),   32'd1);
    cycle(641, 2, 1'b0, '0, '0);
    check("ready_back", 32'(wr_ready), 32'd1);

    // out-of-range write
    base = we_seen;
    cycle(642, 2, 1'b1, 19'(FB_SIZE), 8'h11);
    cycle(643, 2, 1'b0, '0, '0);
    check("oor_err",   32'(wr_err),   32'd1);
    check("oor_ready", 32'(wr_ready), 32'd1);
    cycle(644, 2, 1'b0, '0, '0);
    check("oor_err_pulse", 32'(wr_err), 32'd0);
    for (int i = 645; i < 800; i++) cycle(i, 2, 1'b0, '0, '0);
    check("oor_no_we", 32'(we_seen - base), 32'd0);

    // reset discards a pending write
    for (int i = 0; i < 10; i++) cycle(i, 3, 1'b0, '0, '0);
    cycle(10, 3, 1'b1, 19'd2000, 8'h55);
    for (int i = 11; i < 21; i++) cycle(i, 3, 1'b0, '0, '0);
    reset_cycles(2);
    base = we_seen;
    for (int i = 21; i < 800; i++) cycle(i, 3, 1'b0, '0, '0);
    for (int i = 0; i < 800; i++) cycle(i, 4, 1'b0, '0, '0);
    check("rst_drop_no_we", 32'(we_seen - base), 32'd0);

    // random writes across the bottom of the frame and into vertical blank
    base  = we_seen;
    n_acc = 0;
    for (int yy = 470; yy < 490; yy++) begin
      for (int xx = 0; xx < 800; xx++) begin
        cycle(xx, yy, ($urandom_range(0, 31) == 0),
              19'($urandom_range(0, FB_SIZE + 2000)), 8'($urandom));
      end
    end
    check("rand_we_count", 32'(we_seen - base), 32'(n_acc));
    check("rand_wq_empty", 32'(wq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
